// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//
// Hazard / sequencing controller for a classic five-stage pipeline. It
// arbitrates between exceptions/ERET, data-memory wait states, a multicycle
// divide and load-use hazards. It drives per-register stall (hold) and flush
// (bubble) controls, PC source select and divider handshake pulses.
//
// Ports
//   clk           in   1  rising-edge clock
//   reset         in   1  asynchronous active-high reset
//   id_rs, id_rt  in   5  source registers of the instruction in ID
//   ex_MemRead    in   1  instruction in EX is a load
//   ex_rd         in   5  destination register of the instruction in EX
//   ex_div_start  in   1  divide in EX requests the multicycle divider
//   mem_except    in   1  exception recognised in MEM
//   mem_eret      in   1  ERET recognised in MEM
//   dmem_ready    in   1  data memory has completed the current access
//   stall_*       out  1  hold PC / IF_ID / ID_EX / EX_MEM
//   flush_*       out  1  load a bubble into IF_ID / ID_EX / EX_MEM / MEM_WB
//   pc_sel        out  2  00 sequential/branch, 01 exception vector, 10 EPC
//   div_busy      out  1  divider is holding the pipeline
//   div_done      out  1  one-cycle divide completion pulse
//   div_abort     out  1  one-cycle divide cancel pulse
//
// Outputs are combinational from state, counter and inputs so that the
// pipeline reacts in the same cycle an event is presented. Reset forces all
// outputs low immediately, without waiting for a clock edge.
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_MemRead,
    input  logic [4:0] ex_rd,
    input  logic       ex_div_start,
    input  logic       mem_except,
    input  logic       mem_eret,
    input  logic       dmem_ready,
    output logic       stall_pc,
    output logic       stall_if_id,
    output logic       stall_id_ex,
    output logic       stall_ex_mem,
    output logic       flush_if_id,
    output logic       flush_id_ex,
    output logic       flush_ex_mem,
    output logic       flush_mem_wb,
    output logic [1:0] pc_sel,
    output logic       div_busy,
    output logic       div_done,
    output logic       div_abort
);

    localparam int CNT_W = 6;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_EXC = 2'b01;
    localparam logic [1:0] PC_EPC = 2'b10;

    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN = 2'b00,
        DIV = 2'b01,
        EXC = 2'b10
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    // Raw stall requests before flush-over-stall resolution.
    logic               stall_pc_s;
    logic               stall_if_id_s;
    logic               stall_id_ex_s;
    logic               stall_ex_mem_s;
    logic               load_use_s;
    logic               exc_req_s;
    logic [1:0]         exc_pc_s;

    // Load-use hazard: register 0 is hard-wired zero and never forwards a load.
    always_comb begin
        load_use_s = ex_MemRead && (ex_rd != 5'd0) &&
                     ((ex_rd == id_rs) || (ex_rd == id_rt));
    end

    // Exception request and its PC source; mem_except wins over mem_eret.
    always_comb begin
        exc_req_s = mem_except || mem_eret;
        if (mem_except) begin
            exc_pc_s = PC_EXC;
        end else begin
            exc_pc_s = PC_EPC;
        end
    end

    // Next-state, counter and output decode in priority order:
    // exception/ERET > dmem wait > divide > load-use.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        stall_pc_s     = 1'b0;
        stall_if_id_s  = 1'b0;
        stall_id_ex_s  = 1'b0;
        stall_ex_mem_s = 1'b0;
        flush_if_id    = 1'b0;
        flush_id_ex    = 1'b0;
        flush_ex_mem   = 1'b0;
        flush_mem_wb   = 1'b0;
        pc_sel         = PC_SEQ;
        div_busy       = 1'b0;
        div_done       = 1'b0;
        div_abort      = 1'b0;

        if (reset) begin
            state_d = RUN;
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                RUN: begin
                    if (exc_req_s) begin
                        flush_if_id  = 1'b1;
                        flush_id_ex  = 1'b1;
                        flush_ex_mem = 1'b1;
                        pc_sel       = exc_pc_s;
                        state_d      = EXC;
                    end else if (!dmem_ready) begin
                        // Freeze everything upstream of MEM; WB gets a bubble.
                        stall_pc_s     = 1'b1;
                        stall_if_id_s  = 1'b1;
                        stall_id_ex_s  = 1'b1;
                        stall_ex_mem_s = 1'b1;
                        flush_mem_wb   = 1'b1;
                    end else if (ex_div_start) begin
                        // The start cycle counts as the first held cycle.
                        stall_pc_s     = 1'b1;
                        stall_if_id_s  = 1'b1;
                        stall_id_ex_s  = 1'b1;
                        stall_ex_mem_s = 1'b1;
                        flush_mem_wb   = 1'b1;
                        div_busy       = 1'b1;
                        cnt_d          = DIV_LOAD;
                        state_d        = DIV;
                    end else if (load_use_s) begin
                        stall_pc_s    = 1'b1;
                        stall_if_id_s = 1'b1;
                        flush_id_ex   = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end

                DIV: begin
                    if (exc_req_s) begin
                        flush_if_id  = 1'b1;
                        flush_id_ex  = 1'b1;
                        flush_ex_mem = 1'b1;
                        pc_sel       = exc_pc_s;
                        div_abort    = 1'b1;
                        cnt_d        = {CNT_W{1'b0}};
                        state_d      = EXC;
                    end else if (!dmem_ready) begin
                        // Memory wait freezes the divide count as well.
                        stall_pc_s     = 1'b1;
                        stall_if_id_s  = 1'b1;
                        stall_id_ex_s  = 1'b1;
                        stall_ex_mem_s = 1'b1;
                        flush_mem_wb   = 1'b1;
                        div_busy       = 1'b1;
                    end else if (cnt_q == {CNT_W{1'b0}}) begin
                        // Completion cycle: pipeline is released this cycle.
                        div_done = 1'b1;
                        state_d  = RUN;
                    end else begin
                        stall_pc_s     = 1'b1;
                        stall_if_id_s  = 1'b1;
                        stall_id_ex_s  = 1'b1;
                        stall_ex_mem_s = 1'b1;
                        flush_mem_wb   = 1'b1;
                        div_busy       = 1'b1;
                        cnt_d          = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end

                EXC: begin
                    // One-cycle recovery slot: squash the wrong-path fetch,
                    // ignore all requests, resume normal sequencing next cycle.
                    flush_if_id = 1'b1;
                    state_d     = RUN;
                end

                default: begin
                    // Unreachable encoding: recover to a clean RUN state.
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = RUN;
                end
            endcase
        end
    end

    // Flush wins over stall for any pipeline register driven by both.
    always_comb begin
        stall_pc     = stall_pc_s;
        stall_if_id  = stall_if_id_s  & ~flush_if_id;
        stall_id_ex  = stall_id_ex_s  & ~flush_id_ex;
        stall_ex_mem = stall_ex_mem_s & ~flush_ex_mem;
    end

    // State and divide counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       ex_MemRead;
    logic [4:0] ex_rd;
    logic       ex_div_start;
    logic       mem_except;
    logic       mem_eret;
    logic       dmem_ready;
    logic       stall_pc;
    logic       stall_if_id;
    logic       stall_id_ex;
    logic       stall_ex_mem;
    logic       flush_if_id;
    logic       flush_id_ex;
    logic       flush_ex_mem;
    logic       flush_mem_wb;
    logic [1:0] pc_sel;
    logic       div_busy;
    logic       div_done;
    logic       div_abort;

    int checks;
    int passes;

    pipeline_ctrl #(.DIV_CYCLES(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_MemRead   (ex_MemRead),
        .ex_rd        (ex_rd),
        .ex_div_start (ex_div_start),
        .mem_except   (mem_except),
        .mem_eret     (mem_eret),
        .dmem_ready   (dmem_ready),
        .stall_pc     (stall_pc),
        .stall_if_id  (stall_if_id),
        .stall_id_ex  (stall_id_ex),
        .stall_ex_mem (stall_ex_mem),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .flush_ex_mem (flush_ex_mem),
        .flush_mem_wb (flush_mem_wb),
        .pc_sel       (pc_sel),
        .div_busy     (div_busy),
        .div_done     (div_done),
        .div_abort    (div_abort)
    );

    // Output bundle: {stall pc,if_id,id_ex,ex_mem, flush if_id,id_ex,ex_mem,mem_wb, pc_sel, busy, done, abort}
    logic [12:0] obs;
    assign obs = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
                  flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
                  pc_sel, div_busy, div_done, div_abort};

    localparam logic [12:0] E_IDLE  = 13'b0000_0000_00_000;
    localparam logic [12:0] E_LU    = 13'b1100_0100_00_000;
    localparam logic [12:0] E_WAIT  = 13'b1111_0001_00_000;
    localparam logic [12:0] E_DIVH  = 13'b1111_0001_00_100;
    localparam logic [12:0] E_DONE  = 13'b0000_0000_00_010;
    localparam logic [12:0] E_EXCV  = 13'b0000_1110_01_000;
    localparam logic [12:0] E_ERETV = 13'b0000_1110_10_000;
    localparam logic [12:0] E_ABORT = 13'b0000_1110_01_001;
    localparam logic [12:0] E_EXCST = 13'b0000_1000_00_000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        id_rs        = 5'd0;
        id_rt        = 5'd0;
        ex_MemRead   = 1'b0;
        ex_rd        = 5'd0;
        ex_div_start = 1'b0;
        mem_except   = 1'b0;
        mem_eret     = 1'b0;
        dmem_ready   = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        ex_div_start = 1'b1;
        mem_except   = 1'b1;
        #1;
        checks++;
        if (obs !== E_IDLE) $display("FAIL reset_outputs got=%b want=%b", obs, E_IDLE);
        else passes++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== E_IDLE) $display("FAIL reset_release_idle got=%b want=%b", obs, E_IDLE);
        else passes++;
    endtask

    task automatic test_load_use();
        @(negedge clk); idle_inputs();
        ex_MemRead = 1'b1; ex_rd = 5'd5; id_rt = 5'd5; id_rs = 5'd3;
        #1; checks++;
        if (obs !== E_LU) $display("FAIL load_use_rt got=%b want=%b", obs, E_LU);
        else passes++;
        @(negedge clk); idle_inputs();
        #1; checks++;
        if (obs !== E_IDLE) $display("FAIL load_use_single_cycle got=%b want=%b", obs, E_IDLE);
        else passes++;
        @(negedge clk); idle_inputs();
        ex_MemRead = 1'b1; ex_rd = 5'd0; id_rt = 5'd0; id_rs = 5'd0;
        #1; checks++;
        if (obs !== E_IDLE) $display("FAIL load_use_r0 got=%b want=%b", obs, E_IDLE);
        else passes++;
        @(negedge clk); idle_inputs();
        ex_MemRead = 1'b1; ex_rd = 5'd17; id_rs = 5'd17; id_rt = 5'd2;
        #1; checks++;
        if (obs !== E_LU) $display("FAIL load_use_rs got=%b want=%b", obs, E_LU);
        else passes++;
        @(negedge clk); idle_inputs();
        ex_MemRead = 1'b1; ex_rd = 5'd9; id_rs = 5'd8; id_rt = 5'd10;
        #1; checks++;
        if (obs !== E_IDLE) $display("FAIL load_no_match got=%b want=%b", obs, E_IDLE);
        else passes++;
        @(negedge clk); idle_inputs();
        ex_MemRead = 1'b0; ex_rd = 5'd9; id_rs = 5'd9;
        #1; checks++;
        if (obs !== E_IDLE) $display("FAIL nonload_match got=%b want=%b", obs, E_IDLE);
        else passes++;
    endtask

    task automatic test_dmem_wait();
        @(negedge clk); idle_inputs();
        dmem_ready = 1'b0;
        #1; checks++;
        if (obs !== E_WAIT) $display("FAIL dmem_wait got=%b want=%b", obs, E_WAIT);
        else passes++;
        @(negedge clk); idle_inputs();
        dmem_ready = 1'b0; ex_MemRead = 1'b1; ex_rd = 5'd4; id_rs = 5'd4;
        #1; checks++;
        if (obs !== E_WAIT) $display("FAIL dmem_over_load_use got=%b want=%b", obs, E_WAIT);
        else passes++;
        @(negedge clk); idle_inputs();
        dmem_ready = 1'b0; ex_div_start = 1'b1;
        #1; checks++;
        if (obs !== E_WAIT) $display("FAIL dmem_over_div got=%b want=%b", obs, E_WAIT);
        else passes++;
        @(negedge clk); idle_inputs();
        #1; checks++;
        if (obs !== E_IDLE) $display("FAIL dmem_wait_no_div got=%b want=%b", obs, E_IDLE);
        else passes++;
    endtask

    task automatic test_divide();
        int busy_cycles;
        busy_cycles = 0;
        @(negedge clk); idle_inputs();
        ex_div_start = 1'b1;
        #1; checks++;
        if (obs !== E_DIVH) $display("FAIL div_start got=%b want=%b", obs, E_DIVH);
        else passes++;
        if (div_busy === 1'b1) busy_cycles++;
        for (int i = 1; i <= 31; i++) begin
            @(negedge clk); idle_inputs();
            if (i == 5) ex_div_start = 1'b1;
            if (i == 7) begin ex_MemRead = 1'b1; ex_rd = 5'd6; id_rs = 5'd6; end
            #1; checks++;
            if (obs !== E_DIVH) $display("FAIL div_hold cycle=%0d got=%b want=%b", i, obs, E_DIVH);
            else passes++;
            if (div_busy === 1'b1) busy_cycles++;
        end
        @(negedge clk); idle_inputs();
        #1; checks++;
        if (obs !== E_DONE) $display("FAIL div_done got=%b want=%b", obs, E_DONE);
        else passes++;
        checks++;
        if (busy_cycles !== 32) $display("FAIL div_busy_count got=%0d want=32", busy_cycles);
        else passes++;
        @(negedge clk); idle_inputs();
        #1; checks++;
        if (obs !== E_IDLE) $display("FAIL div_back_to_run got=%b want=%b", obs, E_IDLE);
        else passes++;
    endtask

    task automatic test_div_wait();
        int dones;
        dones = 0;
        @(negedge clk); idle_inputs();
        ex_div_start = 1'b1;
        #1; checks++;
        if (obs !== E_DIVH) $display("FAIL divw_start got=%b want=%b", obs, E_DIVH);
        else passes++;
        for (int i = 1; i <= 34; i++) begin
            @(negedge clk); idle_inputs();
            if (i >= 10 && i <= 12) dmem_ready = 1'b0;
            #1; checks++;
            if (obs !== E_DIVH) $display("FAIL divw_hold cycle=%0d got=%b want=%b", i, obs, E_DIVH);
            else passes++;
            if (div_done === 1'b1) dones++;
        end
        @(negedge clk); idle_inputs();
        #1; checks++;
        if (obs !== E_DONE) $display("FAIL divw_done got=%b want=%b", obs, E_DONE);
        else passes++;
        if (div_done === 1'b1) dones++;
        @(negedge clk); idle_inputs();
        #1;
        if (div_done === 1'b1) dones++;
        checks++;
        if (dones !== 1) $display("FAIL divw_done_count got=%0d want=1", dones);
        else passes++;
    endtask

    task automatic test_div_abort();
        @(negedge clk); idle_inputs();
        ex_div_start = 1'b1;
        #1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk); idle_inputs();
            #1;
        end
        checks++;
        if (obs !== E_DIVH) $display("FAIL abort_pre_hold got=%b want=%b", obs, E_DIVH);
        else passes++;
        @(negedge clk); idle_inputs();
        mem_except = 1'b1;
        #1; checks++;
        if (obs !== E_ABORT) $display("FAIL div_abort got=%b want=%b", obs, E_ABORT);
        else passes++;
        // EXC ignores exceptions, divide requests and memory wait.
        @(negedge clk); idle_inputs();
        mem_except = 1'b1; ex_div_start = 1'b1; dmem_ready = 1'b0;
        #1; checks++;
        if (obs !== E_EXCST) $display("FAIL abort_exc_state got=%b want=%b", obs, E_EXCST);
        else passes++;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); idle_inputs();
            #1; checks++;
            if (obs !== E_IDLE) $display("FAIL abort_no_done cycle=%0d got=%b want=%b", i, obs, E_IDLE);
            else passes++;
        end
    endtask

    task automatic test_exc_priority();
        @(negedge clk); idle_inputs();
        mem_except = 1'b1; mem_eret = 1'b1;
        #1; checks++;
        if (obs !== E_EXCV) $display("FAIL exc_and_eret got=%b want=%b", obs, E_EXCV);
        else passes++;
        @(negedge clk); idle_inputs();
        #1; checks++;
        if (obs !== E_EXCST) $display("FAIL exc_state1 got=%b want=%b", obs, E_EXCST);
        else passes++;
        @(negedge clk); idle_inputs();
        mem_eret = 1'b1;
        #1; checks++;
        if (obs !== E_ERETV) $display("FAIL eret_only got=%b want=%b", obs, E_ERETV);
        else passes++;
        @(negedge clk); idle_inputs();
        #1; checks++;
        if (obs !== E_EXCST) $display("FAIL exc_state2 got=%b want=%b", obs, E_EXCST);
        else passes++;
        @(negedge clk); idle_inputs();
        mem_except = 1'b1; dmem_ready = 1'b0; ex_div_start = 1'b1;
        ex_MemRead = 1'b1; ex_rd = 5'd3; id_rt = 5'd3;
        #1; checks++;
        if (obs !== E_EXCV) $display("FAIL exc_over_all got=%b want=%b", obs, E_EXCV);
        else passes++;
        @(negedge clk); idle_inputs();
        #1; checks++;
        if (obs !== E_EXCST) $display("FAIL exc_state3 got=%b want=%b", obs, E_EXCST);
        else passes++;
        @(negedge clk); idle_inputs();
        #1; checks++;
        if (obs !== E_IDLE) $display("FAIL exc_back_to_run got=%b want=%b", obs, E_IDLE);
        else passes++;
    endtask

    task automatic test_reset_mid_div();
        @(negedge clk); idle_inputs();
        ex_div_start = 1'b1;
        #1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk); idle_inputs();
            #1;
        end
        checks++;
        if (obs !== E_DIVH) $display("FAIL rst_pre_hold got=%b want=%b", obs, E_DIVH);
        else passes++;
        #1 reset = 1'b1;
        #1; checks++;
        if (obs !== E_IDLE) $display("FAIL rst_immediate got=%b want=%b", obs, E_IDLE);
        else passes++;
        @(posedge clk);
        #1; checks++;
        if (obs !== E_IDLE) $display("FAIL rst_held got=%b want=%b", obs, E_IDLE);
        else passes++;
        @(negedge clk); idle_inputs();
        reset = 1'b0;
        #1; checks++;
        if (obs !== E_IDLE) $display("FAIL rst_release got=%b want=%b", obs, E_IDLE);
        else passes++;
        @(negedge clk); idle_inputs();
        ex_div_start = 1'b1;
        #1; checks++;
        if (obs !== E_DIVH) $display("FAIL rst_restart got=%b want=%b", obs, E_DIVH);
        else passes++;
        for (int i = 1; i <= 31; i++) begin
            @(negedge clk); idle_inputs();
            #1;
        end
        checks++;
        if (obs !== E_DIVH) $display("FAIL rst_restart_last_hold got=%b want=%b", obs, E_DIVH);
        else passes++;
        @(negedge clk); idle_inputs();
        #1; checks++;
        if (obs !== E_DONE) $display("FAIL rst_restart_done got=%b want=%b", obs, E_DONE);
        else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        reset  = 1'b1;
        idle_inputs();
        test_reset();
        test_load_use();
        test_dmem_wait();
        test_divide();
        test_div_wait();
        test_div_abort();
        test_exc_priority();
        test_reset_mid_div();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 32, meaning number of cycles the pipeline is held per divide (range 2..63).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port id_rs, id_rt  input  5 each  source register numbers of the instruction in ID.
REQ-005 SHALL have port ex_MemRead, ex_rd  input  1 / 5  EX-stage load flag and destination register.
REQ-006 SHALL have port ex_div_start  input  1  divide instruction in EX requests the multicycle divider.
REQ-007 SHALL have port mem_except, mem_eret  input  1 each  exception / ERET recognised in MEM.
REQ-008 SHALL have port dmem_ready  input  1  data memory has completed the current access.
REQ-009 SHALL have ports stall_pc, stall_if_id, stall_id_ex, stall_ex_mem  output  1 each  hold the register (no load).
REQ-010 SHALL have ports flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb  output  1 each  load a bubble (all control fields 0).
REQ-011 SHALL have port pc_sel  output  2  00 sequential/branch, 01 exception vector, 10 EPC (ERET).
REQ-012 SHALL have ports div_busy, div_done, div_abort  output  1 each  divider hold, one-cycle completion pulse, one-cycle cancel pulse.

Function
REQ-013 SHALL implement states RUN, DIV, EXC; outputs are combinational from state, counter and inputs.
REQ-014 SHALL apply priority per cycle: exception/ERET > dmem wait > divide > load-use.
REQ-015 Exception: in RUN or DIV with mem_except=1 or mem_eret=1 -> flush_if_id, flush_id_ex, flush_ex_mem = 1, pc_sel = 01 (mem_except) or 10 (mem_eret only; mem_except wins if both), next state EXC.
REQ-016 Exception in DIV SHALL assert div_abort=1 that cycle, clear the counter, and SHALL NOT assert div_done.
REQ-017 EXC SHALL last exactly one cycle: flush_if_id=1, pc_sel=00, all stalls 0, exception inputs ignored; next state RUN.
REQ-018 Dmem wait: dmem_ready=0 (no exception) -> all four stalls = 1, flush_mem_wb = 1, state and counter hold.
REQ-019 Divide: in RUN, ex_div_start=1 -> load counter with DIV_CYCLES-1, next state DIV; that cycle all four stalls = 1, flush_mem_wb = 1, div_busy = 1.
REQ-020 In DIV: all four stalls = 1, flush_mem_wb = 1, div_busy = 1; counter decrements each non-waiting cycle.
REQ-021 In DIV with counter = 0 and dmem_ready=1: div_done = 1, stalls released, next state RUN; total hold = DIV_CYCLES cycles from the start cycle.
REQ-022 ex_div_start SHALL be ignored while in DIV or EXC.
REQ-023 Load-use: in RUN, ex_MemRead=1, ex_rd != 0, ex_rd equal to id_rs or id_rt, no higher-priority event -> stall_pc = stall_if_id = 1, flush_id_ex = 1, single cycle.
REQ-024 ex_rd = 0 SHALL never cause a load-use stall.
REQ-025 A flush and a stall SHALL never both be asserted for the same pipeline register; flush wins.
REQ-026 With no event in RUN all outputs SHALL be 0 and pc_sel = 00.

Reset
REQ-027 reset=1 SHALL immediately, independent of clk, force state RUN, counter 0, and all outputs 0 (pc_sel = 00).
REQ-028 Reset asserted in DIV or EXC SHALL abandon the operation without div_done or div_abort pulses; first cycle after release is RUN.

Verification
REQ-029 Load-use: ex_MemRead=1, ex_rd=5, id_rt=5 for one cycle -> stall_pc=stall_if_id=flush_id_ex=1 that cycle only; repeat with ex_rd=0 -> all outputs 0.
REQ-030 Divide, DIV_CYCLES=32: ex_div_start pulse -> div_busy and stalls high exactly 32 cycles, div_done=1 in cycle 32, RUN next.
REQ-031 Divide with dmem_ready=0 for 3 cycles mid-count -> hold extended to 35 cycles, div_done once.
REQ-032 mem_except=1 at divide cycle 10 -> div_abort=1, three flushes, pc_sel=01; next cycle EXC with flush_if_id=1; no div_done.
REQ-033 mem_except=1 and mem_eret=1 together -> pc_sel=01; mem_eret alone -> pc_sel=10.
REQ-034 reset asserted mid-DIV between clock edges -> outputs 0 immediately; after release, ex_div_start accepted normally.
